// File: rtl/lwb_pkg.sv
// lwb_pkg: shared helpers for line_window_buffer.
//   clamp_col : clamp a signed column index into [0, len-1] (edge replication)
//   win_off   : bit offset of window element (r,c) in the flat output bus
//   ptr_add   : modular add for ring pointers, wrapped explicitly at the bound
package lwb_pkg;

    // Works on full int width so negative and past-the-end columns clamp
    // correctly before any narrowing to the RAM address width.
    function automatic int clamp_col(input int col, input int len);
        if (col < 0)
            return 0;
        else if (col > len - 1)
            return len - 1;
        else
            return col;
    endfunction

    function automatic int win_off(input int r, input int c, input int k, input int w);
        return (r * k + c) * w;
    endfunction

    // Assumes p < m and n < m, so one conditional subtract is enough.
    function automatic int ptr_add(input int p, input int n, input int m);
        int s;
        s = p + n;
        return (s >= m) ? s - m : s;
    endfunction

endpackage

// File: rtl/lwb_line_ram.sv
// lwb_line_ram: one image line of storage.
//   i_clk            clock for the single write port
//   i_we/i_waddr/i_wdata  write port
//   i_raddr[NRD]     read addresses, one per window column
//   o_rdata[NRD]     asynchronous read data (distributed RAM style)
// No reset: contents are don't-care until a line is written.
module lwb_line_ram #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 640,
    parameter int NRD    = 3,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic                       i_clk,
    input  logic                       i_we,
    input  logic [AW-1:0]              i_waddr,
    input  logic [DATA_W-1:0]          i_wdata,
    input  logic [NRD-1:0][AW-1:0]     i_raddr,
    output logic [NRD-1:0][DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we)
            mem[i_waddr] <= i_wdata;
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        assign o_rdata[p] = mem[i_raddr[p]];
    end

endmodule

// File: rtl/line_window_buffer.sv
// line_window_buffer: ring of NUM_LINES line memories producing a
// KERNEL x KERNEL pixel window per output handshake.
//   i_clk, i_rst (async, active high), i_flush (sync pointer clear)
//   i_data/i_data_valid/o_wr_ready : raster pixel write side
//   o_data/o_valid/i_rd_ready      : window output, element (r,c) at
//                                    [(r*KERNEL+c)*DATA_W +: DATA_W], r=0 oldest
//   o_lines    : complete lines currently held
//   o_overflow : sticky, write attempted while not ready
module line_window_buffer
    import lwb_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int LINE_LEN  = 640,
    parameter int KERNEL    = 3,
    parameter int NUM_LINES = 4
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic                              i_flush,
    input  logic [DATA_W-1:0]                 i_data,
    input  logic                              i_data_valid,
    output logic                              o_wr_ready,
    output logic [KERNEL*KERNEL*DATA_W-1:0]   o_data,
    output logic                              o_valid,
    input  logic                              i_rd_ready,
    output logic [$clog2(NUM_LINES+1)-1:0]    o_lines,
    output logic                              o_overflow
);

    localparam int COL_W  = $clog2(LINE_LEN);
    localparam int LINE_W = $clog2(NUM_LINES);
    localparam int CNT_W  = $clog2(NUM_LINES+1);
    localparam int H      = (KERNEL - 1) / 2;
    localparam int WIN_W  = KERNEL * KERNEL * DATA_W;

    logic [COL_W-1:0]  wr_col, rd_col;
    logic [LINE_W-1:0] wr_line, rd_line;
    logic [CNT_W-1:0]  full_cnt;

    logic wr_fire, wr_eol, rd_load, rd_eol;

    logic [KERNEL-1:0][COL_W-1:0]                  rd_addr;
    logic [NUM_LINES-1:0][KERNEL-1:0][DATA_W-1:0]  rdata;
    logic [WIN_W-1:0]                              win;

    // wr_line always sits just past the held lines (rd_line + full_cnt), so
    // while fewer than NUM_LINES lines are held the line being filled can
    // never alias one still awaiting reads. Pure function of registers.
    assign o_wr_ready = (full_cnt < CNT_W'(NUM_LINES));
    assign o_lines    = full_cnt;

    assign wr_fire = i_data_valid && o_wr_ready;
    assign wr_eol  = wr_fire && (wr_col == COL_W'(LINE_LEN - 1));
    assign rd_load = (full_cnt >= CNT_W'(KERNEL)) && (!o_valid || i_rd_ready);
    assign rd_eol  = rd_load && (rd_col == COL_W'(LINE_LEN - 1));

    for (genvar i = 0; i < NUM_LINES; i++) begin : g_line
        lwb_line_ram #(
            .DATA_W (DATA_W),
            .DEPTH  (LINE_LEN),
            .NRD    (KERNEL),
            .AW     (COL_W)
        ) u_ram (
            .i_clk   (i_clk),
            .i_we    (wr_fire && !i_flush && (wr_line == LINE_W'(i))),
            .i_waddr (wr_col),
            .i_wdata (i_data),
            .i_raddr (rd_addr),
            .o_rdata (rdata[i])
        );
    end

    // All lines share the same clamped column addresses; edge columns
    // replicate instead of wrapping into the neighbouring line.
    for (genvar c = 0; c < KERNEL; c++) begin : g_addr
        assign rd_addr[c] = COL_W'(clamp_col(int'(rd_col) + c - H, LINE_LEN));
    end

    // Row rotation: window row r comes from ring slot rd_line + r.
    for (genvar r = 0; r < KERNEL; r++) begin : g_row
        logic [LINE_W-1:0] row_sel;
        assign row_sel = LINE_W'(ptr_add(int'(rd_line), r, NUM_LINES));
        for (genvar c = 0; c < KERNEL; c++) begin : g_col
            assign win[win_off(r, c, KERNEL, DATA_W) +: DATA_W] = rdata[row_sel][c];
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_col     <= '0;
            wr_line    <= '0;
            rd_col     <= '0;
            rd_line    <= '0;
            full_cnt   <= '0;
            o_valid    <= 1'b0;
            o_data     <= '0;
            o_overflow <= 1'b0;
        end else begin
            if (i_data_valid && !o_wr_ready)
                o_overflow <= 1'b1;

            if (i_flush) begin
                wr_col   <= '0;
                wr_line  <= '0;
                rd_col   <= '0;
                rd_line  <= '0;
                full_cnt <= '0;
                o_valid  <= 1'b0;
            end else begin
                if (wr_fire) begin
                    if (wr_eol) begin
                        wr_col  <= '0;
                        wr_line <= LINE_W'(ptr_add(int'(wr_line), 1, NUM_LINES));
                    end else begin
                        wr_col  <= wr_col + 1'b1;
                    end
                end

                if (rd_load) begin
                    o_data  <= win;
                    o_valid <= 1'b1;
                    if (rd_eol) begin
                        rd_col  <= '0;
                        rd_line <= LINE_W'(ptr_add(int'(rd_line), 1, NUM_LINES));
                    end else begin
                        rd_col  <= rd_col + 1'b1;
                    end
                end else if (i_rd_ready) begin
                    o_valid <= 1'b0;
                end

                // Completion and release in the same cycle cancel out.
                if (wr_eol && !rd_eol)
                    full_cnt <= full_cnt + 1'b1;
                else if (rd_eol && !wr_eol)
                    full_cnt <= full_cnt - 1'b1;
            end
        end
    end

endmodule
